sipo_deserializer: RTL and testbench
====================================

# sipo_deserializer

Synchronous serial-in/parallel-out deserializer that collects a framed serial bit stream into a WIDTH-bit word. It is the upstream feed stage for the counter/register datapath: it produces one registered word plus a one-cycle valid strobe per frame. All state is clocked by a single `clk`; no derived or ripple clocks are used.

## Interface
- `WIDTH`, default 4: data bits per frame; legal range 2..16.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  single-cycle frame start; opens or restarts a frame.
- `din`  in  1  serial data bit, MSB first.
- `din_valid`  in  1  qualifies `din`; one bit is consumed per cycle where it is high.
- `q`  out  WIDTH  last completed word; holds until the next completion.
- `q_valid`  out  1  one-cycle strobe: `q` was updated this cycle.
- `busy`  out  1  high while a frame is open (SHIFT or PARITY).
- `bit_cnt`  out  5  data bits received in the current frame (0..WIDTH-1).
- `parity_err`  out  1  present only with `SIPO_PARITY_EN`; see Configuration.

## Operation
- States:
  - IDLE: `busy`=0.
  - SHIFT: collecting data bits.
  - PARITY: collecting the parity bit; exists only with the macro.
- Reset (`rst`=1 at an edge):
  - state←IDLE.
  - `q`, `q_valid`, `busy`, `bit_cnt`, `parity_err` and the shift register all ←0.
  - `rst` overrides every other input.
- IDLE:
  - `start`=1 → SHIFT; `bit_cnt`←0; shift register←0.
  - `din_valid` is ignored.
- SHIFT, `start`=0, `din_valid`=1:
  - shreg←{shreg[WIDTH-2:0], din}.
  - If `bit_cnt`<WIDTH-1: `bit_cnt`++.
  - If `bit_cnt`==WIDTH-1 and macro off: `q`←{shreg[WIDTH-2:0], din}; `q_valid`←1; `bit_cnt`←0; →IDLE.
  - If `bit_cnt`==WIDTH-1 and macro on: →PARITY; `q` is not yet updated.
- SHIFT/PARITY, `din_valid`=0: hold all state.
- SHIFT/PARITY, `start`=1: abort and restart the frame.
  - `bit_cnt`←0; shreg←0; state→SHIFT.
  - No `q_valid`; `q` keeps its old value.
  - `start` has priority over a simultaneous `din_valid`; that bit is discarded.
- `q_valid` is registered and deasserts the following cycle unless another completion occurs.
- `bit_cnt` wraps to 0 on frame completion; it never reaches WIDTH.

## Timing
- Frame latency: `q`/`q_valid` appear the cycle after the edge that samples the last data bit (macro off) or the parity bit (macro on).
- Back-to-back frames:
  - `start` is accepted in the same cycle `q_valid`=1, because state is already IDLE.
  - Minimum frame period: WIDTH+1 cycles (macro off) or WIDTH+2 cycles (macro on).
- `busy` rises the cycle after `start` is sampled and falls in the same cycle `q_valid` rises.
- Reset mid-frame: the next cycle shows all outputs 0 and no `q_valid`. The partial frame is lost.

## Configuration
- Macro: `SIPO_PARITY_EN`.
- Defined:
  - After the WIDTH data bits, one extra even-parity bit is consumed in PARITY.
  - On that bit: `q`←data word; `q_valid`←1; `parity_err`←^{data word, parity bit}; →IDLE.
  - `parity_err` is valid while `q_valid`=1 and holds until the next completion or reset.
  - Abort via `start` works in PARITY exactly as in SHIFT.
- Undefined: no PARITY state and no `parity_err` port; frames are exactly WIDTH bits.

## Test plan
- Reset then basic frame (WIDTH=4, macro off): `start`, then `din`=1,0,1,1 on consecutive `din_valid` cycles → `q`=4'b1011 with a single `q_valid` pulse one cycle after the 4th bit; `busy` is 0 in that same cycle.
- Gapped input: same bits with `din_valid` low for 3 cycles between bits 2 and 3 → `q`=4'b1011; `bit_cnt` holds at 2 during the gap; no early `q_valid`.
- Abort: `start`, bits 1,1, then `start` again, then bits 0,1,1,0 → exactly one `q_valid`, with `q`=4'b0110.
- Back-to-back: second `start` in the `q_valid` cycle of frame 1010, then frame 0101 → `q`=1010 then 0101; `q_valid` pulses exactly WIDTH+1 cycles apart.
- Reset mid-frame: after 2 bits assert `rst` → next cycle `q`=0, `busy`=0, `bit_cnt`=0; no `q_valid` until a new full frame arrives.
- `SIPO_PARITY_EN`: data 1011 with parity 1 → `q`=1011, `parity_err`=0. Data 1011 with parity 0 → `q`=1011, `parity_err`=1.

Source files
------------

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: collects a framed, MSB-first serial bit stream into a WIDTH-bit word.
// Latency: q/q_valid appear one cycle after the edge that samples the final bit of a frame.
// Backpressure: none; din_valid qualifies each bit. Define SIPO_PARITY_EN to add a trailing even-parity bit.
module sipo_deserializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             busy,
`ifdef SIPO_PARITY_EN
  output logic             parity_err,
`endif
  output logic [4:0]       bit_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  // Count value of the final data bit within a frame.
  localparam logic [4:0] LAST_BIT = 5'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] r_q;
  logic             r_q_valid;
  logic             r_busy;
  logic [4:0]       r_bit_cnt;
  logic [WIDTH-1:0] w_shifted;
`ifdef SIPO_PARITY_EN
  logic             r_parity_err;
`endif

  // Shift register contents once the current din bit has been appended.
  assign w_shifted = {r_shreg[WIDTH-2:0], din};

  // Frame FSM: start always (re)opens a frame, otherwise din_valid consumes one bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shreg   <= '0;
      r_q       <= '0;
      r_q_valid <= 1'b0;
      r_busy    <= 1'b0;
      r_bit_cnt <= 5'd0;
`ifdef SIPO_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_q_valid <= 1'b0;
      if (start) begin
        // Opening from IDLE and aborting an open frame are the same action.
        r_state   <= SHIFT;
        r_shreg   <= '0;
        r_bit_cnt <= 5'd0;
        r_busy    <= 1'b1;
      end else if (din_valid) begin
        case (r_state)
          SHIFT: begin
            r_shreg <= w_shifted;
            if (r_bit_cnt == LAST_BIT) begin
`ifdef SIPO_PARITY_EN
              // Data word complete; bit_cnt stays at its last value until the parity bit lands.
              r_state <= PARITY;
`else
              r_q       <= w_shifted;
              r_q_valid <= 1'b1;
              r_bit_cnt <= 5'd0;
              r_busy    <= 1'b0;
              r_state   <= IDLE;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
          end
`ifdef SIPO_PARITY_EN
          PARITY: begin
            // Even parity: the XOR of data and parity bit must be zero.
            r_q          <= r_shreg;
            r_q_valid    <= 1'b1;
            r_parity_err <= ^{r_shreg, din};
            r_bit_cnt    <= 5'd0;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end
`endif
          IDLE: begin
            // Stray bits outside a frame are ignored.
            r_state <= IDLE;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign q       = r_q;
  assign q_valid = r_q_valid;
  assign busy    = r_busy;
  assign bit_cnt = r_bit_cnt;
`ifdef SIPO_PARITY_EN
  assign parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: directed frames with literal expectations, then random traffic
// compared every cycle against a queue-based frame model.
module tb_sipo_deserializer;

  localparam int WIDTH = 4;
`ifdef SIPO_PARITY_EN
  localparam int FRAME_BITS = WIDTH + 1;
`else
  localparam int FRAME_BITS = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             din = 1'b0;
  logic             din_valid = 1'b0;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             busy;
  logic [4:0]       bit_cnt;
`ifdef SIPO_PARITY_EN
  logic             parity_err;
`endif

  sipo_deserializer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .din        (din),
    .din_valid  (din_valid),
    .q          (q),
    .q_valid    (q_valid),
    .busy       (busy),
`ifdef SIPO_PARITY_EN
    .parity_err (parity_err),
`endif
    .bit_cnt    (bit_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int qv_seen = 0;
  int last_qv_cycle = 0;

  // Reference model: an open flag plus the list of bits received so far in the frame.
  bit   m_open = 1'b0;
  bit   m_bits[$];
  logic [WIDTH-1:0] m_q = '0;
  logic m_qv = 1'b0;
  logic m_pe = 1'b0;

  function automatic logic [WIDTH-1:0] pack_bits();
    logic [WIDTH-1:0] w = '0;
    for (int i = 0; i < WIDTH; i++) w = {w[WIDTH-2:0], logic'(m_bits[i])};
    return w;
  endfunction

  function automatic void model_step(input logic r, input logic s, input logic v, input logic d);
    logic [WIDTH-1:0] w;
    m_qv = 1'b0;
    if (r) begin
      m_open = 1'b0; m_bits.delete(); m_q = '0; m_pe = 1'b0;
    end else if (s) begin
      m_open = 1'b1; m_bits.delete();
    end else if (m_open && v) begin
      m_bits.push_back(d);
      if (m_bits.size() == FRAME_BITS) begin
        w = pack_bits();
        m_q  = w;
        m_qv = 1'b1;
`ifdef SIPO_PARITY_EN
        // Count of ones over data plus parity must be even.
        m_pe = logic'(($countones(w) + int'(d)) % 2);
`endif
        m_open = 1'b0;
        m_bits.delete();
      end
    end
  endfunction

  // Data bits counted so far; in the parity phase it stays at the last data index.
  function automatic int model_cnt();
    if (!m_open) return 0;
    if (m_bits.size() >= WIDTH) return WIDTH - 1;
    return m_bits.size();
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cycle, act, exp);
    end
  endtask

  // Compare every DUT output against the model.
  task automatic compare_all();
    chk("q", 32'(q), 32'(m_q));
    chk("q_valid", 32'(q_valid), 32'(m_qv));
    chk("busy", 32'(busy), 32'(m_open));
    chk("bit_cnt", 32'(bit_cnt), 32'(model_cnt()));
`ifdef SIPO_PARITY_EN
    chk("parity_err", 32'(parity_err), 32'(m_pe));
`endif
  endtask

  // One clock: drive inputs, let the edge happen, update the model, compare mid-cycle.
  task automatic cyc(input logic r, input logic s, input logic v, input logic d);
    rst = r; start = s; din_valid = v; din = d;
    @(posedge clk);
    model_step(r, s, v, d);
    @(negedge clk);
    cycle++;
    if (q_valid === 1'b1) begin
      qv_seen++;
      last_qv_cycle = cycle;
    end
    compare_all();
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] w, input logic par);
    cyc(0, 1, 0, 0);
    for (int i = WIDTH - 1; i >= 0; i--) cyc(0, 0, 1, w[i]);
`ifdef SIPO_PARITY_EN
    cyc(0, 0, 1, par);
`else
    if (par) begin end
`endif
  endtask

  int qv_before;
  int first_qv;

  initial begin
    // Reset
    @(negedge clk);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 1);
    chk("reset_q", 32'(q), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_cnt", 32'(bit_cnt), 32'h0);
    chk("reset_qv", 32'(q_valid), 32'h0);

    // Bits before any start are ignored
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 0);
    chk("idle_ignore_busy", 32'(busy), 32'h0);

    // Basic frame 1011 (parity 1 is correct even parity)
    send_frame(4'b1011, 1'b1);
    chk("basic_q", 32'(q), 32'hB);
    chk("basic_qv", 32'(q_valid), 32'h1);
    chk("basic_busy", 32'(busy), 32'h0);
`ifdef SIPO_PARITY_EN
    chk("parity_ok", 32'(parity_err), 32'h0);
`endif
    cyc(0, 0, 0, 0);
    chk("qv_one_cycle", 32'(q_valid), 32'h0);
    chk("q_holds", 32'(q), 32'hB);

`ifdef SIPO_PARITY_EN
    // Same data, wrong parity
    send_frame(4'b1011, 1'b0);
    chk("parity_bad_q", 32'(q), 32'hB);
    chk("parity_bad", 32'(parity_err), 32'h1);
    cyc(0, 0, 0, 0);
    chk("parity_err_holds", 32'(parity_err), 32'h1);
`endif

    // Gapped frame: 1,0, three idle cycles, 1,1
    qv_before = qv_seen;
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1);
      chk("gap_cnt", 32'(bit_cnt), 32'd2);
      chk("gap_busy", 32'(busy), 32'h1);
    end
    cyc(0, 0, 1, 1);
    chk("gap_no_early_qv", 32'(qv_seen - qv_before), 32'd0);
    cyc(0, 0, 1, 1);
`ifdef SIPO_PARITY_EN
    cyc(0, 0, 1, 1);
`endif
    chk("gap_q", 32'(q), 32'hB);
    chk("gap_qv", 32'(q_valid), 32'h1);

    // Abort: start, 1,1, start, then 0110 (start wins over a simultaneous bit)
    qv_before = qv_seen;
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 1);
    cyc(0, 1, 1, 1);
    chk("abort_cnt", 32'(bit_cnt), 32'd0);
    chk("abort_q_kept", 32'(q), 32'hB);
    for (int i = WIDTH - 1; i >= 0; i--) cyc(0, 0, 1, 1'((4'b0110 >> i) & 4'b1));
`ifdef SIPO_PARITY_EN
    cyc(0, 0, 1, 0);
`endif
    cyc(0, 0, 0, 0);
    chk("abort_one_qv", 32'(qv_seen - qv_before), 32'd1);
    chk("abort_q", 32'(q), 32'h6);

    // Back-to-back: next start in the q_valid cycle
    send_frame(4'b1010, 1'b0);
    chk("b2b_q1", 32'(q), 32'hA);
    first_qv = last_qv_cycle;
    send_frame(4'b0101, 1'b0);
    chk("b2b_q2", 32'(q), 32'h5);
    chk("b2b_period", 32'(last_qv_cycle - first_qv), 32'(FRAME_BITS + 1));

    // Reset mid-frame
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 1);
    cyc(1, 0, 1, 1);
    chk("midrst_q", 32'(q), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_cnt", 32'(bit_cnt), 32'h0);
    qv_before = qv_seen;
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 1);
    chk("midrst_no_qv", 32'(qv_seen - qv_before), 32'd0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
          1'($urandom_range(0, 1)));
    end
    chk("random_frames_seen", 32'(qv_seen > 20), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
